// File: rtl/seg7_scan_decoder.sv
// Readback monitor for the multiplexed active-low 7-segment bus: synchronizes
// the pins, waits for a stable {anode, segment} pair and decodes it per digit.

module seg7_digit_slot (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iWe,
  input  logic [3:0] iDig,
  input  logic       iValid,
  input  logic       iBlank,
  output logic [3:0] oDig,
  output logic       oValid,
  output logic       oBlank,
  output logic       oChg
);
  assign oChg = iWe && ({iDig, iValid, iBlank} != {oDig, oValid, oBlank});

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDig   <= 4'hF;
      oValid <= 1'b0;
      oBlank <= 1'b1;
    end else if (iWe) begin
      oDig   <= iDig;
      oValid <= iValid;
      oBlank <= iBlank;
    end
  end
endmodule

module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [6:0]        iSeg,
  input  logic [NDIG-1:0]   iAn,
  input  logic              iErrClr,
  output logic [4*NDIG-1:0] oDigits,
  output logic [NDIG-1:0]   oValid,
  output logic [NDIG-1:0]   oBlank,
  output logic              oErr,
  output logic              oUpdate
);
  localparam int SW   = NDIG + 7;
  localparam int CW   = $clog2(STABLE_CYC + 1);
  localparam int ZW   = $clog2(NDIG + 1);
  localparam int SELW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [SW-1:0]   sync1, sync2;
  logic [CW-1:0]   cnt;
  logic [6:0]      segS;
  logic [NDIG-1:0] anS;
  logic [ZW-1:0]   zeros;
  logic [SELW-1:0] sel;
  logic            oneLow, cap;
  logic [3:0]      decDig;
  logic            decValid, decBlank, decIllegal;
  logic [NDIG-1:0] chg;

  assign segS = sync2[6:0];
  assign anS  = sync2[SW-1:7];

  // Stability is judged between the two sync stages so a capture lands at
  // edge STABLE_CYC+2 after the pins change; a metastable first stage can
  // only restart the window, never corrupt the captured value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      cnt   <= '0;
    end else begin
      sync1 <= {iAn, iSeg};
      sync2 <= sync1;
      if (sync1 != sync2)             cnt <= '0;
      else if (cnt != CW'(STABLE_CYC)) cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    zeros = '0;
    sel   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!anS[i]) begin
        zeros = zeros + ZW'(1);
        sel   = SELW'(i);
      end
    end
  end

  assign oneLow = (zeros == ZW'(1));
  assign cap    = (sync1 == sync2) && (cnt == CW'(STABLE_CYC - 1)) && oneLow;

  always_comb begin
    decDig     = 4'hE;
    decValid   = 1'b1;
    decBlank   = 1'b0;
    decIllegal = 1'b0;
    case (segS)
      7'b1000000: decDig = 4'd0;
      7'b1111001: decDig = 4'd1;
      7'b0100100: decDig = 4'd2;
      7'b0110000: decDig = 4'd3;
      7'b0011001: decDig = 4'd4;
      7'b0010010: decDig = 4'd5;
      7'b0000010: decDig = 4'd6;
      7'b1111000: decDig = 4'd7;
      7'b0000000: decDig = 4'd8;
      7'b0010000: decDig = 4'd9;
      7'b1111111: begin
        decDig   = 4'hF;
        decValid = 1'b0;
        decBlank = 1'b1;
      end
      default: begin
        decValid   = 1'b0;
        decIllegal = 1'b1;
      end
    endcase
  end

  for (genvar i = 0; i < NDIG; i++) begin : gSlot
    seg7_digit_slot uSlot (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iWe    (cap && (sel == SELW'(i))),
      .iDig   (decDig),
      .iValid (decValid),
      .iBlank (decBlank),
      .oDig   (oDigits[4*i+3:4*i]),
      .oValid (oValid[i]),
      .oBlank (oBlank[i]),
      .oChg   (chg[i])
    );
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oUpdate <= 1'b0;
      oErr    <= 1'b0;
    end else begin
      oUpdate <= |chg;
      if (cap && decIllegal) oErr <= 1'b1;
      else if (iErrClr)      oErr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: vector table for steady scans plus
// hand sequences for latency, error clear races and mid-window reset.

module tb_seg7_scan_decoder;
  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [6:0]  iSeg;
  logic [3:0]  iAn;
  logic        iErrClr;
  logic [15:0] oDigits;
  logic [3:0]  oValid, oBlank;
  logic        oErr, oUpdate;

  int nVec = 0;
  int nErr = 0;
  int updCnt = 0;

  seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSeg(iSeg), .iAn(iAn), .iErrClr(iErrClr),
    .oDigits(oDigits), .oValid(oValid), .oBlank(oBlank), .oErr(oErr),
    .oUpdate(oUpdate)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oUpdate === 1'b1) updCnt++;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  blk;
    logic        err;
    int          upd;
  } vec_t;

  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S8 = 7'b0000000;
  localparam logic [6:0] SBAD = 7'b0111111, SOFF = 7'b1111111;

  vec_t tabA[12];
  vec_t tabB[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    iAn  = an;
    iSeg = seg;
    repeat (n) @(negedge iClk);
    #1;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int base;
    base = updCnt;
    hold(v.an, v.seg, v.cyc);
    chk({tag, " digits"}, 32'(oDigits), 32'(v.dig));
    chk({tag, " valid"},  32'(oValid),  32'(v.val));
    chk({tag, " blank"},  32'(oBlank),  32'(v.blk));
    chk({tag, " err"},    32'(oErr),    32'(v.err));
    chk({tag, " updates"}, 32'(updCnt - base), 32'(v.upd));
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " digits"}, 32'(oDigits), 32'h0000FFFF);
    chk({tag, " valid"},  32'(oValid),  32'h0);
    chk({tag, " blank"},  32'(oBlank),  32'hF);
    chk({tag, " err"},    32'(oErr),    32'h0);
    chk({tag, " upd"},    32'(oUpdate), 32'h0);
  endtask

  initial begin
    int base;
    // glitch, recapture, scan twice, illegal then legal on digit 1
    tabA[0]  = '{4'b1110, S1,   5,  16'hFFF2, 4'b0001, 4'b1110, 1'b0, 0};
    tabA[1]  = '{4'b1110, S2,   12, 16'hFFF2, 4'b0001, 4'b1110, 1'b0, 0};
    tabA[2]  = '{4'b0111, S1,   16, 16'h1FF2, 4'b1001, 4'b0110, 1'b0, 1};
    tabA[3]  = '{4'b1011, S2,   16, 16'h12F2, 4'b1101, 4'b0010, 1'b0, 1};
    tabA[4]  = '{4'b1101, S3,   16, 16'h1232, 4'b1111, 4'b0000, 1'b0, 1};
    tabA[5]  = '{4'b1110, S4,   16, 16'h1234, 4'b1111, 4'b0000, 1'b0, 1};
    tabA[6]  = '{4'b0111, S1,   16, 16'h1234, 4'b1111, 4'b0000, 1'b0, 0};
    tabA[7]  = '{4'b1011, S2,   16, 16'h1234, 4'b1111, 4'b0000, 1'b0, 0};
    tabA[8]  = '{4'b1101, S3,   16, 16'h1234, 4'b1111, 4'b0000, 1'b0, 0};
    tabA[9]  = '{4'b1110, S4,   16, 16'h1234, 4'b1111, 4'b0000, 1'b0, 0};
    tabA[10] = '{4'b1101, SBAD, 12, 16'h12E4, 4'b1101, 4'b0000, 1'b1, 1};
    tabA[11] = '{4'b1101, S5,   12, 16'h1254, 4'b1111, 4'b0000, 1'b1, 1};
    // bad anode patterns, then blank on digit 2
    tabB[0]  = '{4'b1100, S8,   20, 16'h12E4, 4'b1101, 4'b0000, 1'b0, 0};
    tabB[1]  = '{4'b1111, S8,   20, 16'h12E4, 4'b1101, 4'b0000, 1'b0, 0};
    tabB[2]  = '{4'b1011, SOFF, 16, 16'h1FE4, 4'b1001, 4'b0100, 1'b0, 1};

    iRst_n = 1'b0; iAn = 4'hF; iSeg = SOFF; iErrClr = 1'b0;
    repeat (3) @(negedge iClk);
    #1 chkReset("reset");
    iRst_n = 1'b1;
    repeat (3) @(negedge iClk);
    #1;

    // latency: capture lands on edge 10 after the pins change
    base = updCnt;
    iAn = 4'b1110; iSeg = S2;
    repeat (9) @(negedge iClk);
    #1 chk("lat edge9 digit0", 32'(oDigits[3:0]), 32'hF);
    @(negedge iClk);
    #1 chk("lat edge10 digit0", 32'(oDigits[3:0]), 32'h2);
    chk("lat edge10 valid0", 32'(oValid[0]), 32'h1);
    chk("lat edge10 blank0", 32'(oBlank[0]), 32'h0);
    chk("lat edge10 update", 32'(oUpdate), 32'h1);
    repeat (10) @(negedge iClk);
    #1 chk("lat pulse count", 32'(updCnt - base), 32'h1);

    foreach (tabA[i]) runVec(tabA[i], $sformatf("vecA%0d", i));

    iErrClr = 1'b1;
    @(negedge iClk);
    #1 iErrClr = 1'b0;
    chk("errclr", 32'(oErr), 32'h0);

    // clear coincident with an illegal capture: set wins
    iAn = 4'b1101; iSeg = SBAD;
    repeat (9) @(negedge iClk);
    #1 iErrClr = 1'b1;
    @(negedge iClk);
    #1 iErrClr = 1'b0;
    chk("clr+illegal err", 32'(oErr), 32'h1);
    chk("clr+illegal digit1", 32'(oDigits[7:4]), 32'hE);
    iErrClr = 1'b1;
    @(negedge iClk);
    #1 iErrClr = 1'b0;
    chk("errclr2", 32'(oErr), 32'h0);

    foreach (tabB[i]) runVec(tabB[i], $sformatf("vecB%0d", i));

    // reset in the middle of a stable window
    hold(4'b1110, S8, 6);
    #1 iRst_n = 1'b0;
    #1 chkReset("midreset");
    repeat (2) @(negedge iClk);
    #1 iRst_n = 1'b1;
    repeat (5) @(negedge iClk);
    #1 chk("post-reset no partial", 32'(oDigits), 32'hFFFF);
    repeat (8) @(negedge iClk);
    #1 chk("post-reset capture", 32'(oDigits), 32'hFFF8);
    chk("post-reset valid", 32'(oValid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
